// File: rtl/watch_rtc_if.sv
// Bundled control, set, alarm and time-output signals for the watch RTC core.
// The slave side is the RTC; the master side is the set/alarm front end and display.
interface watch_rtc_if #(
    parameter int NUM_ALARMS = 2
);
    logic                  run;
    logic                  set_valid;
    logic [51:0]           set_data;
    logic [2:0]            set_week;
    logic                  set_err;
    logic                  alarm_wr;
    logic [2:0]            alarm_idx;
    logic                  alarm_en_in;
    logic [7:0]            alarm_hour_in;
    logic [7:0]            alarm_min_in;
    logic [11:0]           year;
    logic [7:0]            month;
    logic [7:0]            day;
    logic [7:0]            hour;
    logic [7:0]            minute;
    logic [7:0]            second;
    logic [2:0]            week;
    logic [4:0]            max_date;
    logic                  sec_pulse;
    logic [NUM_ALARMS-1:0] alarm_hit;

    modport slave (
        input  run, set_valid, set_data, set_week,
        input  alarm_wr, alarm_idx, alarm_en_in, alarm_hour_in, alarm_min_in,
        output set_err, year, month, day, hour, minute, second, week, max_date,
        output sec_pulse, alarm_hit
    );

    modport master (
        output run, set_valid, set_data, set_week,
        output alarm_wr, alarm_idx, alarm_en_in, alarm_hour_in, alarm_min_in,
        input  set_err, year, month, day, hour, minute, second, week, max_date,
        input  sec_pulse, alarm_hit
    );
endinterface

// File: rtl/watch_rtc.sv
// Calendar RTC with internal 1 s prescaler, validated atomic set and hour:minute alarms.
// Latency: set/tick land on the sampling edge, pulses follow one cycle later; no backpressure, requests always accepted.
module watch_rtc #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int YEAR_MIN   = 1,
    parameter int YEAR_MAX   = 4095,
    parameter int NUM_ALARMS = 2
) (
    input logic         clk,
    input logic         rst,
    watch_rtc_if.slave  bus
);
    localparam int              PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [11:0]     Y_MIN    = 12'(YEAR_MIN);
    localparam logic [11:0]     Y_MAX    = 12'(YEAR_MAX);

    function automatic logic [4:0] month_days(input logic [11:0] y, input logic [7:0] m);
        logic leap;
        leap = (((y % 12'd4) == 12'd0) && ((y % 12'd100) != 12'd0)) || ((y % 12'd400) == 12'd0);
        case (m)
            8'd2:                    month_days = leap ? 5'd29 : 5'd28;
            8'd4, 8'd6, 8'd9, 8'd11: month_days = 5'd30;
            default:                 month_days = 5'd31;
        endcase
    endfunction

    logic [PW-1:0] presc;
    logic [11:0]   yr_q;
    logic [7:0]    mon_q, day_q, hr_q, min_q, sec_q;
    logic [2:0]    wk_q;
    logic          err_q, pulse_q;
    logic [NUM_ALARMS-1:0] hit_q, hit_nxt;
    logic          al_en  [NUM_ALARMS];
    logic [7:0]    al_hr  [NUM_ALARMS];
    logic [7:0]    al_min [NUM_ALARMS];

    logic [11:0]   s_year;
    logic [7:0]    s_mon, s_day, s_hour, s_min, s_sec;
    logic          set_ok, load, tick;
    logic [4:0]    cur_max;
    logic [11:0]   n_yr;
    logic [7:0]    n_mon, n_day, n_hr, n_min, n_sec;
    logic [2:0]    n_wk;

    assign {s_year, s_mon, s_day, s_hour, s_min, s_sec} = bus.set_data;

    // Legality is judged against the requested date itself, not the current one.
    assign set_ok = (s_year >= Y_MIN) && (s_year <= Y_MAX)
                 && (s_mon >= 8'd1) && (s_mon <= 8'd12)
                 && (s_day >= 8'd1) && (s_day <= {3'b000, month_days(s_year, s_mon)})
                 && (s_hour < 8'd24) && (s_min < 8'd60) && (s_sec < 8'd60)
                 && (bus.set_week != 3'd7);
    assign load    = bus.set_valid && set_ok;
    assign tick    = bus.run && (presc == PRE_LAST);
    assign cur_max = month_days(yr_q, mon_q);

    always_comb begin
        n_yr  = yr_q;
        n_mon = mon_q;
        n_day = day_q;
        n_hr  = hr_q;
        n_min = min_q;
        n_sec = sec_q + 8'd1;
        n_wk  = wk_q;
        if (sec_q == 8'd59) begin
            n_sec = 8'd0;
            n_min = min_q + 8'd1;
            if (min_q == 8'd59) begin
                n_min = 8'd0;
                n_hr  = hr_q + 8'd1;
                if (hr_q == 8'd23) begin
                    n_hr  = 8'd0;
                    n_wk  = (wk_q == 3'd6) ? 3'd0 : wk_q + 3'd1;
                    n_day = day_q + 8'd1;
                    if (day_q == {3'b000, cur_max}) begin
                        n_day = 8'd1;
                        n_mon = mon_q + 8'd1;
                        if (mon_q == 8'd12) begin
                            n_mon = 8'd1;
                            n_yr  = (yr_q == Y_MAX) ? Y_MIN : yr_q + 12'd1;
                        end
                    end
                end
            end
        end
    end

    // Matches use the pre-write alarm registers, so a same-cycle rewrite cannot cancel a hit.
    always_comb begin
        hit_nxt = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            hit_nxt[i] = al_en[i] && (n_hr == al_hr[i]) && (n_min == al_min[i]) && (n_sec == 8'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc   <= '0;
            yr_q    <= 12'd2021;
            mon_q   <= 8'd5;
            day_q   <= 8'd30;
            hr_q    <= 8'd18;
            min_q   <= 8'd32;
            sec_q   <= 8'd0;
            wk_q    <= 3'd0;
            err_q   <= 1'b0;
            pulse_q <= 1'b0;
            hit_q   <= '0;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                al_en[i]  <= 1'b0;
                al_hr[i]  <= 8'd0;
                al_min[i] <= 8'd0;
            end
        end else begin
            err_q   <= bus.set_valid && !set_ok;
            pulse_q <= 1'b0;
            hit_q   <= '0;
            if (load) begin
                presc <= '0;
                yr_q  <= s_year;
                mon_q <= s_mon;
                day_q <= s_day;
                hr_q  <= s_hour;
                min_q <= s_min;
                sec_q <= s_sec;
                wk_q  <= bus.set_week;
            end else if (bus.run) begin
                if (tick) begin
                    presc   <= '0;
                    yr_q    <= n_yr;
                    mon_q   <= n_mon;
                    day_q   <= n_day;
                    hr_q    <= n_hr;
                    min_q   <= n_min;
                    sec_q   <= n_sec;
                    wk_q    <= n_wk;
                    pulse_q <= 1'b1;
                    hit_q   <= hit_nxt;
                end else begin
                    presc <= presc + PW'(1);
                end
            end
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (bus.alarm_wr && (int'(bus.alarm_idx) == i)) begin
                    al_en[i]  <= bus.alarm_en_in;
                    al_hr[i]  <= bus.alarm_hour_in;
                    al_min[i] <= bus.alarm_min_in;
                end
            end
        end
    end

    assign bus.year      = yr_q;
    assign bus.month     = mon_q;
    assign bus.day       = day_q;
    assign bus.hour      = hr_q;
    assign bus.minute    = min_q;
    assign bus.second    = sec_q;
    assign bus.week      = wk_q;
    assign bus.max_date  = cur_max;
    assign bus.set_err   = err_q;
    assign bus.sec_pulse = pulse_q;
    assign bus.alarm_hit = hit_q;
endmodule

// File: doc/watch_rtc.md
# watch_rtc

Parametrised real-time-clock core for the watch datapath and the successor of the fixed 1 Hz time/date counter. It divides the system clock internally to a one-second tick and keeps year/month/day/hour/minute/second plus a day-of-week counter. It provides a validated, atomic set port, a run/stop control, and NUM_ALARMS independent hour:minute alarm channels. Display and alarm-sound logic sit downstream; the set path is driven by the button/UART front end.

## Interface
- TICK_DIV, 50_000_000: clk cycles per second; legal range ≥ 1.
- YEAR_MIN, 1: lowest legal year; the year wraps to this value.
- YEAR_MAX, 4095: highest legal year; must satisfy YEAR_MIN ≤ YEAR_MAX ≤ 4095.
- NUM_ALARMS, 2: number of alarm channels; legal range 1..8.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- run  in  1  1 = prescaler counts; 0 = prescaler and time are frozen.
- set_valid  in  1  one-cycle request to load set_data and set_week.
- set_data  in  52  {year[11:0], month[7:0], day[7:0], hour[7:0], minute[7:0], second[7:0]}.
- set_week  in  3  day of week, 0 = Sunday … 6 = Saturday.
- set_err  out  1  one-cycle pulse: the last set request was rejected.
- alarm_wr  in  1  write the alarm channel selected by alarm_idx.
- alarm_idx  in  3  alarm channel index; values ≥ NUM_ALARMS are ignored.
- alarm_en_in, alarm_hour_in[7:0], alarm_min_in[7:0]  in  alarm write data.
- year  out  12; month, day, hour, minute, second  out  8 each: current time.
- week  out  3  current day of week.
- max_date  out  5  number of days in the current month.
- sec_pulse  out  1  one-cycle pulse on the cycle a ticked time first appears on the outputs.
- alarm_hit  out  NUM_ALARMS  per-channel one-cycle match pulse.

## Operation
- Reset values: 2021-05-30 18:32:00, week=0 (Sunday). Prescaler=0. All alarms: en=0, hour=0, min=0. set_err, sec_pulse and alarm_hit are 0.
- Prescaler:
  - Counts 0..TICK_DIV-1 while run=1.
  - An internal tick occurs when the prescaler equals TICK_DIV-1 and run=1; the prescaler returns to 0 on that cycle.
  - With TICK_DIV=1, every run cycle is a tick.
- Tick increments the time with a full carry chain:
  - second 59→0 carries into minute; minute 59→0 carries into hour; hour 23→0 carries into day.
  - Day carry: day==max_date→1 and month+1, otherwise day+1. Week advances (week+1) mod 7 on every day carry.
  - month 12→1 carries into year.
  - year==YEAR_MAX→YEAR_MIN, otherwise year+1.
- max_date is combinational from the current month and year: 31/30 per calendar; February is 29 if (y%4==0 && y%100!=0) || y%400==0, else 28.
- Set validation uses a leap rule and max_date computed from set_data's own year and month. The request is legal only if all of the following hold:
  - YEAR_MIN ≤ year ≤ YEAR_MAX
  - 1 ≤ month ≤ 12
  - 1 ≤ day ≤ max(set month, set year)
  - hour < 24, minute < 60, second < 60
  - set_week < 7
- Legal set: all fields and week load atomically, and the prescaler clears to 0. Illegal set: no state changes and set_err pulses.
- Alarm channel i fires (alarm_hit[i]=1) when all of the following hold in the same cycle:
  - sec_pulse=1
  - en_i=1
  - hour==alarm_hour_i, minute==alarm_min_i, second==0
- A set never produces alarm_hit or sec_pulse.
- An alarm register holding hour ≥ 24 or min ≥ 60 is stored as written and never matches.

## Timing
- All state is registered. A tick at edge N updates the time registers at edge N; sec_pulse=1 during the cycle after edge N.
- Tick period is exactly TICK_DIV cycles while run=1. Deasserting run holds the prescaler value, so a run gap adds no phase error.
- Set: set_valid sampled at edge N → new time is visible after edge N. set_err pulses in the cycle after edge N.
- Set and tick in the same cycle: set wins, the tick is discarded, and the prescaler restarts at 0.
- Set while run=0: the set loads, and time remains frozen.
- alarm_wr and an alarm match in the same cycle: the match uses the old alarm contents; the new contents take effect from the next cycle.
- alarm_hit is registered alongside sec_pulse, so both appear in the same cycle.
- rst has priority over everything. A reset mid-count returns to the reset values on the next edge with no pulses.

## Test plan
- TICK_DIV=4, from reset: run=1 for 8 cycles → sec_pulse on 2 cycles spaced 4 apart; second 0→1→2. Hold run=0 for 10 cycles → no change; resume → phase continues from the held prescaler value.
- Set 2024-02-28 23:59:59, week=3; one tick → 2024-02-29 00:00:00, week=4, max_date=29. Set 2100-02-28 23:59:59; one tick → 2100-03-01, since 2100 is not a leap year.
- Set year 4095-12-31 23:59:59 with YEAR_MIN=1; one tick → 0001-01-01 00:00:00, week+1 mod 7.
- Illegal sets (2023-02-29, month=13, hour=24, week=7) → set_err pulse and time unchanged. Legal set asserted on the prescaler's last count → tick discarded, prescaler=0.
- Program alarm 0 = 07:30 with en=1, and alarm 1 = 07:30 with en=0. Set 07:29:59 → after one tick alarm_hit=01 together with sec_pulse. Rewrite alarm 0 on that same cycle → this hit is still reported.
- Assert rst in the middle of the carry chain (at 23:59:59 with a tick pending) → all outputs return to the reset values, alarms clear, and no pulses occur.
